stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 86 ++++++++
 tb/tb_stopwatch_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: two-key stopwatch counting elapsed seconds 00..99 in BCD
//   clk      in   single clock, all logic on posedge
//   rst      in   synchronous active-high reset
//   key_ss   in   raw start/stop button (async, active-high)
//   key_clr  in   raw clear button (async, active-high)
//   data     out  elapsed seconds, [7:4] tens / [3:0] ones BCD
//   running  out  high while in RUN
//   wrap     out  one-cycle pulse on 99 -> 00 rollover
module stopwatch_ctrl #(
  parameter int TICK_DIV     = 40_000_000,
  parameter int DEBOUNCE_CYC = 400_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ss,
  input  logic       key_clr,
  output logic [7:0] data,
  output logic       running,
  output logic       wrap
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  logic [1:0] key, press;
  assign key = {key_clr, key_ss};
  for (genvar g = 0; g < 2; g++) begin : g_key
    logic s1_q, s2_q, acc_q, acc_p_q;
    logic [DW-1:0] cnt_q;
    // counter only runs while the synchronized level disagrees with the accepted one,
    // so any return to the accepted level (a bounce) clears it
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        acc_q   <= 1'b0;
        acc_p_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        s1_q    <= key[g];
        s2_q    <= s1_q;
        acc_p_q <= acc_q;
        if (s2_q == acc_q) cnt_q <= '0;
        else if (cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
          acc_q <= s2_q;
          cnt_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
      end
    end
    assign press[g] = acc_q & ~acc_p_q;
  end
  logic          ss_p, clr_p, tick;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    data_q, data_d, inc;
  logic          running_q, wrap_q;
  assign ss_p  = press[0];
  assign clr_p = press[1];
  assign tick  = state_q == RUN && pre_q == PW'(TICK_DIV - 1);
  always_comb begin
    inc[3:0] = data_q[3:0] == 4'd9 ? 4'd0 : data_q[3:0] + 4'd1;
    inc[7:4] = data_q[3:0] != 4'd9 ? data_q[7:4] : data_q[7:4] == 4'd9 ? 4'd0 : data_q[7:4] + 4'd1;
    state_d  = clr_p ? IDLE : ss_p ? (state_q == RUN ? PAUSE : RUN) : state_q;
    pre_d    = (clr_p || tick || state_q == IDLE) ? '0 : state_q == RUN ? pre_q + 1'b1 : pre_q;
    data_d   = clr_p ? 8'h00 : tick ? inc : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      data_q    <= 8'h00;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      data_q    <= data_d;
      running_q <= state_d == RUN;
      wrap_q    <= !clr_p && tick && data_q == 8'h99;
    end
  end
  assign data    = data_q;
  assign running = running_q;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed bench for stopwatch_ctrl with TICK_DIV=10, DEBOUNCE_CYC=4
module tb_stopwatch_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_ss = 1'b0;
  logic       key_clr = 1'b0;
  logic [7:0] data;
  logic       running, wrap;
  int         n_run = 0;
  int         n_fail = 0;
  stopwatch_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYC(4)) dut (
    .clk(clk), .rst(rst), .key_ss(key_ss), .key_clr(key_clr),
    .data(data), .running(running), .wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [7:0] bcd(input int v);
    return {4'((v % 100) / 10), 4'(v % 10)};
  endfunction
  initial begin
    cyc(3);
    chk("rst_data", data, 8'h00);
    chk("rst_run", 8'(running), 8'h00);
    chk("rst_wrap", 8'(wrap), 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_ss = 1'b1;
      cyc(2);
      key_ss = 1'b0;
      cyc(2);
    end
    cyc(10);
    chk("bounce_run", 8'(running), 8'h00);
    chk("bounce_data", data, 8'h00);
    key_ss = 1'b1;
    cyc(6);
    chk("start_early", 8'(running), 8'h00);
    cyc(1);
    chk("start_run", 8'(running), 8'h01);
    cyc(3);
    key_ss = 1'b0;
    cyc(6);
    chk("first_t9", data, 8'h00);
    cyc(1);
    chk("first_t10", data, 8'h01);
    cyc(9);
    chk("pre_pause", data, 8'h01);
    key_ss = 1'b1;
    cyc(7);
    chk("pause_run", 8'(running), 8'h00);
    chk("pause_data", data, 8'h02);
    key_ss = 1'b0;
    cyc(50);
    chk("pause_hold", data, 8'h02);
    chk("pause_run2", 8'(running), 8'h00);
    key_ss = 1'b1;
    cyc(7);
    chk("resume_run", 8'(running), 8'h01);
    key_ss = 1'b0;
    cyc(3);
    chk("resume_r3", data, 8'h02);
    cyc(1);
    chk("resume_r4", data, 8'h03);
    for (int k = 1; k <= 96; k++) begin
      cyc(10);
      chk("count", data, bcd(3 + k));
    end
    cyc(9);
    chk("wrap_pre_data", data, 8'h99);
    chk("wrap_pre", 8'(wrap), 8'h00);
    cyc(1);
    chk("wrap_data", data, 8'h00);
    chk("wrap_pulse", 8'(wrap), 8'h01);
    chk("wrap_run", 8'(running), 8'h01);
    cyc(1);
    chk("wrap_once", 8'(wrap), 8'h00);
    chk("wrap_hold", data, 8'h00);
    cyc(364);
    key_ss = 1'b1;
    key_clr = 1'b1;
    cyc(6);
    chk("both_pre_data", data, 8'h37);
    chk("both_pre_run", 8'(running), 8'h01);
    cyc(1);
    chk("both_data", data, 8'h00);
    chk("both_run", 8'(running), 8'h00);
    chk("both_wrap", 8'(wrap), 8'h00);
    key_ss = 1'b0;
    key_clr = 1'b0;
    cyc(10);
    chk("both_idle_data", data, 8'h00);
    chk("both_idle_run", 8'(running), 8'h00);
    key_ss = 1'b1;
    cyc(7);
    chk("mid_run", 8'(running), 8'h01);
    key_ss = 1'b0;
    cyc(425);
    chk("mid_data", data, 8'h42);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_run", 8'(running), 8'h00);
    chk("mid_rst_wrap", 8'(wrap), 8'h00);
    rst = 1'b0;
    cyc(30);
    chk("post_rst_data", data, 8'h00);
    chk("post_rst_run", 8'(running), 8'h00);
    rst = 1'b1;
    key_ss = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(6);
    chk("held_early", 8'(running), 8'h00);
    cyc(1);
    chk("held_run", 8'(running), 8'h01);
    key_ss = 1'b0;
    cyc(13);
    chk("clr_tick_pre", data, 8'h01);
    key_clr = 1'b1;
    cyc(6);
    chk("clr_tick_t19", data, 8'h01);
    chk("clr_tick_run19", 8'(running), 8'h01);
    cyc(1);
    chk("clr_tick_data", data, 8'h00);
    chk("clr_tick_wrap", 8'(wrap), 8'h00);
    chk("clr_tick_run", 8'(running), 8'h00);
    key_clr = 1'b0;
    cyc(10);
    chk("clr_idle_data", data, 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
